exec_cc_stage: RTL and testbench
================================

Name: exec_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline. Consumes the ALU result and overflow flag.
- Holds the ZF/SF/OF condition-code register and evaluates jXX/cmovXX conditions.
- Registers the E-to-M pipeline register with Y86 stall/bubble control. Sits between the ALU and the memory stage.

Parameters:
- W, 64, datapath width of ALU result, valA and valE.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- e_valid  input  1  instruction present in E
- e_stat  input  3  status code: AOK=1, HLT=2, ADR=3, INS=4
- e_icode  input  4  instruction code
- e_ifun  input  4  function/condition code
- alu_result  input  W  ALU output
- alu_overflow  input  1  ALU signed-overflow flag
- e_valA  input  W  valA forwarded from decode
- e_dstE  input  4  destination for valE
- e_dstM  input  4  destination for valM
- set_cc_en  input  1  pipeline control; 0 when M/W hold an exception
- m_stall  input  1  hold the E/M register
- m_bubble  input  1  load a NOP into the E/M register
- zf, sf, of  output  1 each  current CC register
- e_cnd  output  1  combinational condition result for the instruction in E
- M_valid, M_stat[2:0], M_icode[3:0], M_ifun[3:0], M_cnd, M_valE[W-1:0], M_valA[W-1:0], M_dstE[3:0], M_dstM[3:0]  output  registered E/M fields

Behaviour:
- Reset (rst high at the edge, overrides everything):
  - zf=1, sf=0, of=0.
  - M_valid=0, M_stat=1, M_icode=1 (NOP), M_ifun=0, M_cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
- CC write. Condition: e_valid & (e_icode==6, OPq) & set_cc_en & !m_stall & (e_stat==1).
  - When true, the next edge loads zf=(alu_result==0), sf=alu_result[W-1], of=alu_overflow.
  - Otherwise CC holds.
  - m_bubble alone does not block the CC write; set_cc_en does.
- Condition evaluation (e_cnd) is combinational from the registered CC, i.e. the value before this cycle's write.
  - ifun 0: 1
  - ifun 1 (le): (sf^of)|zf
  - ifun 2 (l): sf^of
  - ifun 3 (e): zf
  - ifun 4 (ne): !zf
  - ifun 5 (ge): !(sf^of)
  - ifun 6 (g): !(sf^of)&!zf
  - ifun 7-15: 0
  - e_cnd is only meaningful for icode 2 and 7, but is always driven.
- M_dstE loads RNONE when e_icode==2 and e_cnd==0 (untaken cmov); otherwise it loads e_dstE.
- E/M register, in priority order:
  - rst: reset values.
  - m_stall: hold all fields. Stall wins over a simultaneous bubble.
  - m_bubble: reset values except M_valid=0. This is a NOP bubble, stat AOK.
  - !e_valid: same as bubble.
  - Otherwise load every field from E. M_valE=alu_result, M_cnd=e_cnd, M_valid=1.
- Latency: one cycle from E inputs to M outputs. CC is visible to the next instruction's e_cnd one cycle after the OPq is in E, which is back-to-back with no extra delay.
- No width extension: all W-bit fields pass through unchanged.

Optional Feature:
- Macro COND_ILLEGAL_EN.
- When defined: a valid e_icode of 2 or 7 with e_ifun>6 and e_stat==1 loads M_stat=4 (INS). It also forces M_dstE=RNONE. The CC register is unaffected.
- When undefined: such instructions behave as cnd=0 and M_stat=e_stat.

Test Plan:
- Reset: rst=1 for 2 cycles -> zf=1, sf=0, of=0, M_icode=1, M_valid=0, M_dstE=F.
- OPq sub with alu_result=0, overflow=0, then jXX ifun=3 next cycle:
  - -> after edge zf=1, sf=0, of=0.
  - -> jXX e_cnd=1, and M_cnd=1 one edge later.
- OPq with alu_result=64'h8000_0000_0000_0000, overflow=1:
  - -> sf=1, of=1, zf=0.
  - -> following ifun=2 (l) gives e_cnd=0; ifun=5 (ge) gives e_cnd=1.
- cmovXX e_dstE=3, ifun=4, with zf=1 -> M_dstE=F, M_valE=alu_result. Repeat with zf=0 -> M_dstE=3.
- OPq with set_cc_en=0, or with m_stall=1 -> CC unchanged. With m_stall=1 and m_bubble=1 together -> M fields hold their prior values.
- rst asserted mid-stream, in the same cycle an OPq writes result 0 -> CC resets to zf=1, sf=0, of=0, not the OPq values. With COND_ILLEGAL_EN, jXX ifun=9 -> M_stat=4, M_dstE=F.

Source files
------------

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: Y86-64 execute back end (condition codes, jXX/cmovXX evaluation, E/M pipeline register).
// Optional macro COND_ILLEGAL_EN: a valid jXX/cmovXX with ifun>6 becomes an INS exception.
`default_nettype none

module exec_cc_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e_valid,
  input  logic [2:0]   e_stat,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic         set_cc_en,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         e_cnd,
  output logic         M_valid,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic [3:0]   M_ifun,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  localparam logic [3:0] I_CMOV = 4'd2;
  localparam logic [3:0] I_OPQ  = 4'd6;
  localparam logic [3:0] I_JXX  = 4'd7;
  localparam logic [3:0] I_NOP  = 4'd1;
  localparam logic [2:0] S_AOK  = 3'd1;
  localparam logic [2:0] S_INS  = 3'd4;

  logic zf_q, sf_q, of_q;
  logic zf_d, sf_d, of_d;
  logic cc_write;

  logic         valid_q, valid_d;
  logic [2:0]   stat_q, stat_d;
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q, ifun_d;
  logic         cnd_q, cnd_d;
  logic [W-1:0] valE_q, valE_d;
  logic [W-1:0] valA_q, valA_d;
  logic [3:0]   dstE_q, dstE_d;
  logic [3:0]   dstM_q, dstM_d;

  logic         cond_illegal;
  logic [2:0]   stat_sel;
  logic [3:0]   dstE_sel;

  assign cc_write = e_valid && (e_icode == I_OPQ) && set_cc_en && !m_stall && (e_stat == S_AOK);

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_write) begin
      zf_d = (alu_result == '0);
      sf_d = alu_result[W-1];
      of_d = alu_overflow;
    end
  end

  // Evaluated from the registered flags, i.e. before this cycle's write.
  always_comb begin
    e_cnd = 1'b0;
    case (e_ifun)
      4'd0:    e_cnd = 1'b1;
      4'd1:    e_cnd = (sf_q ^ of_q) | zf_q;
      4'd2:    e_cnd = sf_q ^ of_q;
      4'd3:    e_cnd = zf_q;
      4'd4:    e_cnd = !zf_q;
      4'd5:    e_cnd = !(sf_q ^ of_q);
      4'd6:    e_cnd = !(sf_q ^ of_q) && !zf_q;
      default: e_cnd = 1'b0;
    endcase
  end

`ifdef COND_ILLEGAL_EN
  assign cond_illegal = e_valid && ((e_icode == I_CMOV) || (e_icode == I_JXX)) &&
                        (e_ifun > 4'd6) && (e_stat == S_AOK);
`else
  assign cond_illegal = 1'b0;
`endif

  assign stat_sel = cond_illegal ? S_INS : e_stat;
  assign dstE_sel = (cond_illegal || ((e_icode == I_CMOV) && !e_cnd)) ? RNONE : e_dstE;

  always_comb begin
    valid_d = valid_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    cnd_d   = cnd_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    if (m_stall) begin
      // hold
    end else if (m_bubble || !e_valid) begin
      valid_d = 1'b0;
      stat_d  = S_AOK;
      icode_d = I_NOP;
      ifun_d  = 4'd0;
      cnd_d   = 1'b0;
      valE_d  = '0;
      valA_d  = '0;
      dstE_d  = RNONE;
      dstM_d  = RNONE;
    end else begin
      valid_d = 1'b1;
      stat_d  = stat_sel;
      icode_d = e_icode;
      ifun_d  = e_ifun;
      cnd_d   = e_cnd;
      valE_d  = alu_result;
      valA_d  = e_valA;
      dstE_d  = dstE_sel;
      dstM_d  = e_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
      stat_q  <= S_AOK;
      icode_q <= I_NOP;
      ifun_q  <= 4'd0;
      cnd_q   <= 1'b0;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
    end else begin
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      valid_q <= valid_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      cnd_q   <= cnd_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
    end
  end

  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;
  assign M_valid = valid_q;
  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_ifun  = ifun_q;
  assign M_cnd   = cnd_q;
  assign M_valE  = valE_q;
  assign M_valA  = valA_q;
  assign M_dstE  = dstE_q;
  assign M_dstM  = dstM_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_cc_stage.sv
// tb_exec_cc_stage: table-driven bench with an expected-result queue for exec_cc_stage.
`default_nettype none

module tb_exec_cc_stage;

  localparam logic [63:0] H = 64'h8000_0000_0000_0000;
`ifdef COND_ILLEGAL_EN
  localparam logic [2:0] ILL_STAT = 3'd4;
  localparam logic [3:0] ILL_DSTJ = 4'hF;
`else
  localparam logic [2:0] ILL_STAT = 3'd1;
  localparam logic [3:0] ILL_DSTJ = 4'h5;
`endif

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] alu;
    logic        ovf;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        setcc;
    logic        stall;
    logic        bubble;
  } stim_t;

  typedef struct {
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic        mvalid;
    logic [2:0]  mstat;
    logic [3:0]  micode;
    logic [3:0]  mifun;
    logic        mcnd;
    logic [63:0] mvalE;
    logic [63:0] mvalA;
    logic [3:0]  mdstE;
    logic [3:0]  mdstM;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_valid;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode, e_ifun;
  logic [63:0] alu_result, e_valA;
  logic        alu_overflow;
  logic [3:0]  e_dstE, e_dstM;
  logic        set_cc_en, m_stall, m_bubble;
  logic        zf, sf, of, e_cnd;
  logic        M_valid, M_cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode, M_ifun, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;

  int checks = 0;
  int errors = 0;
  vec_t vecs[17];
  exp_t sb[$];

  always #5 clk = ~clk;

  exec_cc_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_stat(e_stat), .e_icode(e_icode),
    .e_ifun(e_ifun), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM), .set_cc_en(set_cc_en),
    .m_stall(m_stall), .m_bubble(m_bubble), .zf(zf), .sf(sf), .of(of), .e_cnd(e_cnd),
    .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
    end
  endtask

  task automatic drive(input stim_t s);
    rst = s.rst; e_valid = s.valid; e_stat = s.stat; e_icode = s.icode; e_ifun = s.ifun;
    alu_result = s.alu; alu_overflow = s.ovf; e_valA = s.valA; e_dstE = s.dstE;
    e_dstM = s.dstM; set_cc_en = s.setcc; m_stall = s.stall; m_bubble = s.bubble;
  endtask

  task automatic check_regs(input int idx, input exp_t e);
    chk("zf", idx, 64'(zf), 64'(e.zf));
    chk("sf", idx, 64'(sf), 64'(e.sf));
    chk("of", idx, 64'(of), 64'(e.of));
    chk("M_valid", idx, 64'(M_valid), 64'(e.mvalid));
    chk("M_stat", idx, 64'(M_stat), 64'(e.mstat));
    chk("M_icode", idx, 64'(M_icode), 64'(e.micode));
    chk("M_ifun", idx, 64'(M_ifun), 64'(e.mifun));
    chk("M_cnd", idx, 64'(M_cnd), 64'(e.mcnd));
    chk("M_valE", idx, M_valE, e.mvalE);
    chk("M_valA", idx, M_valA, e.mvalA);
    chk("M_dstE", idx, 64'(M_dstE), 64'(e.mdstE));
    chk("M_dstM", idx, 64'(M_dstM), 64'(e.mdstM));
  endtask

  initial begin
    exp_t e;
    //             rst valid stat icode ifun alu  ovf valA   dstE  dstM  scc stl bub
    vecs[0]  = '{s:'{0,1,1,6,1,64'h0,0,64'hA0,4'h2,4'hF,1,0,0},
                 e:'{1,1,0,0, 1,1,6,1,1,64'h0,64'hA0,4'h2,4'hF}};
    vecs[1]  = '{s:'{0,1,1,7,3,64'h100,0,64'hA1,4'hF,4'h7,1,0,0},
                 e:'{1,1,0,0, 1,1,7,3,1,64'h100,64'hA1,4'hF,4'h7}};
    vecs[2]  = '{s:'{0,1,1,6,0,H,1,64'hA2,4'h4,4'hF,1,0,0},
                 e:'{1,0,1,1, 1,1,6,0,1,H,64'hA2,4'h4,4'hF}};
    vecs[3]  = '{s:'{0,1,1,7,2,64'h0,0,64'hA3,4'hF,4'hF,1,0,0},
                 e:'{0,0,1,1, 1,1,7,2,0,64'h0,64'hA3,4'hF,4'hF}};
    vecs[4]  = '{s:'{0,1,1,7,5,64'h0,0,64'hA4,4'hF,4'hF,1,0,0},
                 e:'{1,0,1,1, 1,1,7,5,1,64'h0,64'hA4,4'hF,4'hF}};
    vecs[5]  = '{s:'{0,1,1,6,1,64'h0,0,64'hA5,4'h2,4'hF,0,0,0},
                 e:'{0,0,1,1, 1,1,6,1,0,64'h0,64'hA5,4'h2,4'hF}};
    vecs[6]  = '{s:'{0,1,1,2,4,64'h55,0,64'hA6,4'h3,4'hF,1,0,0},
                 e:'{1,0,1,1, 1,1,2,4,1,64'h55,64'hA6,4'h3,4'hF}};
    vecs[7]  = '{s:'{0,1,1,6,1,64'h0,0,64'hA7,4'h2,4'hF,1,0,0},
                 e:'{0,1,0,0, 1,1,6,1,0,64'h0,64'hA7,4'h2,4'hF}};
    vecs[8]  = '{s:'{0,1,1,2,4,64'h66,0,64'hA8,4'h3,4'hF,1,0,0},
                 e:'{0,1,0,0, 1,1,2,4,0,64'h66,64'hA8,4'hF,4'hF}};
    vecs[9]  = '{s:'{0,1,1,6,1,64'h7,0,64'hA9,4'h2,4'hF,1,1,0},
                 e:'{1,1,0,0, 1,1,2,4,0,64'h66,64'hA8,4'hF,4'hF}};
    vecs[10] = '{s:'{0,1,1,6,1,64'h7,0,64'hAA,4'h2,4'hF,1,1,1},
                 e:'{1,1,0,0, 1,1,2,4,0,64'h66,64'hA8,4'hF,4'hF}};
    vecs[11] = '{s:'{0,1,1,6,1,H,0,64'hAB,4'h2,4'hF,1,0,1},
                 e:'{1,0,1,0, 0,1,1,0,0,64'h0,64'h0,4'hF,4'hF}};
    vecs[12] = '{s:'{0,0,1,7,6,64'h0,0,64'hAC,4'h2,4'hF,1,0,0},
                 e:'{0,0,1,0, 0,1,1,0,0,64'h0,64'h0,4'hF,4'hF}};
    vecs[13] = '{s:'{1,1,1,6,1,64'h0,1,64'hAD,4'h2,4'hF,1,0,0},
                 e:'{1,1,0,0, 0,1,1,0,0,64'h0,64'h0,4'hF,4'hF}};
    vecs[14] = '{s:'{0,1,1,7,9,64'h0,0,64'hAE,4'h5,4'hF,1,0,0},
                 e:'{0,1,0,0, 1,ILL_STAT,7,9,0,64'h0,64'hAE,ILL_DSTJ,4'hF}};
    vecs[15] = '{s:'{0,1,1,2,9,64'h12,0,64'hAF,4'h5,4'hF,1,0,0},
                 e:'{0,1,0,0, 1,ILL_STAT,2,9,0,64'h12,64'hAF,4'hF,4'hF}};
    vecs[16] = '{s:'{0,1,2,6,0,H,1,64'hB0,4'h4,4'hF,1,0,0},
                 e:'{1,1,0,0, 1,2,6,0,1,H,64'hB0,4'h4,4'hF}};

    drive('{1,0,1,1,0,64'h0,0,64'h0,4'hF,4'hF,1,0,0});
    repeat (2) @(posedge clk);
    #1;
    e = '{0,1,0,0, 0,1,1,0,0,64'h0,64'h0,4'hF,4'hF};
    check_regs(-1, e);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].s);
      sb.push_back(vecs[i].e);
      #1;
      chk("e_cnd", i, 64'(e_cnd), 64'(vecs[i].e.cnd));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", i, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check_regs(i, e);
      end
    end

    // Back-to-back OPq then jXX with the next flags visible immediately.
    @(negedge clk);
    drive('{0,1,1,6,1,64'h0,0,64'h1,4'h2,4'hF,1,0,0});
    @(negedge clk);
    drive('{0,1,1,7,4,64'h0,0,64'h2,4'hF,4'hF,1,0,0});
    #1;
    chk("b2b_ne_cnd", 17, 64'(e_cnd), 64'd0);
    @(posedge clk);
    #1;
    chk("b2b_M_cnd", 17, 64'(M_cnd), 64'd0);

    @(negedge clk);
    drive('{0,0,1,1,0,64'h0,0,64'h0,4'hF,4'hF,1,0,0});
    @(posedge clk);
    #1;
    chk("idle_valid", 18, 64'(M_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
